// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode values and FSM states.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [0:0] {
    StIdle,
    StMulRun
  } state_e;

endpackage

// File: rtl/alu_comb_w.sv
// Single-cycle W-bit datapath: shared adder for ADD/SUB/INC, logic unit,
// result mux and carry/overflow. MUL yields zero here; the top level owns it.
module alu_comb_w
  import alu_seq_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_in_i,
  input  logic [2:0]   op_i,
  output logic [W-1:0] r_o,
  output logic         carry_o,
  output logic         overflow_o
);

  logic [W-1:0] add_x;
  logic [W-1:0] add_y;
  logic         add_cin;
  logic [W:0]   add_sum;

  // Operand preprocessing so one adder serves ADD, SUB and INC.
  always_comb begin
    add_x   = a_i;
    add_y   = b_i;
    add_cin = c_in_i;
    case (op_i)
      OP_SUB: begin
        add_y   = ~b_i;
        add_cin = 1'b1;
      end
      OP_INC: begin
        add_y   = '0;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

  // Result mux and flags; overflow uses the operand signs the adder actually saw.
  always_comb begin
    r_o        = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB, OP_INC: begin
        r_o        = add_sum[W-1:0];
        carry_o    = add_sum[W];
        overflow_o = (add_x[W-1] == add_y[W-1]) && (add_sum[W-1] != add_x[W-1]);
      end
      OP_AND:  r_o = a_i & b_i;
      OP_OR:   r_o = a_i | b_i;
      OP_XOR:  r_o = a_i ^ b_i;
      OP_NOT:  r_o = ~a_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered W-bit ALU with start/busy/done handshake.
// Define ALU_SEQ_MUL_EN to build the multi-cycle shift-add multiplier;
// without it MUL completes in one cycle with a zero result and busy stays 0.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         c_in,
  input  logic [2:0]   Op,
  output logic [W-1:0] R,
  output logic         zero,
  output logic         carry,
  output logic         sign,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] comb_r;
  logic         comb_carry;
  logic         comb_ovf;

  logic [W-1:0] r_q, r_d;
  logic         zero_q, zero_d;
  logic         carry_q, carry_d;
  logic         sign_q, sign_d;
  logic         ovf_q, ovf_d;
  logic         done_q, done_d;

  alu_comb_w #(
    .W(W)
  ) u_comb (
    .a_i       (A),
    .b_i       (B),
    .c_in_i    (c_in),
    .op_i      (Op),
    .r_o       (comb_r),
    .carry_o   (comb_carry),
    .overflow_o(comb_ovf)
  );

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned CntW = $clog2(W + 1);

  state_e          state_q, state_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]  prod;

  assign prod = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state: single-cycle ops finish from idle; MUL walks one multiplier bit per cycle.
  always_comb begin
    r_d      = r_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (Op == OP_MUL) begin
            state_d  = StMulRun;
            mcand_d  = {{W{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            r_d     = comb_r;
            carry_d = comb_carry;
            ovf_d   = comb_ovf;
            done_d  = 1'b1;
          end
        end
      end
      StMulRun: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) begin
          state_d = StIdle;
          r_d     = prod[W-1:0];
          carry_d = |prod[2*W-1:W];
          ovf_d   = |prod[2*W-1:W];
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // zero/sign track R only when a new result lands, so the reset values hold.
    zero_d = done_d ? (r_d == '0) : zero_q;
    sign_d = done_d ? r_d[W-1] : sign_q;
  end

  // Multiplier and FSM state; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q == StMulRun);
`else
  // Next-state: every op, MUL included, completes one cycle after start.
  always_comb begin
    r_d     = r_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (start) begin
      r_d     = comb_r;
      carry_d = comb_carry;
      ovf_d   = comb_ovf;
      done_d  = 1'b1;
    end
    zero_d = done_d ? (r_d == '0) : zero_q;
    sign_d = done_d ? r_d[W-1] : sign_q;
  end

  assign busy = 1'b0;
`endif

  // Result and flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      r_q     <= r_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign R        = r_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign sign     = sign_q;
  assign overflow = ovf_q;
  assign done     = done_q;

endmodule
